// File: rtl/ls_issue_queue_pkg.sv
// ls_issue_queue_pkg
//   Shared types and constants for the in-order load/store issue queue.
//   Holds the default tag/address widths, the operand/offset widths, the
//   opcode encoding, the per-entry control struct and the effective-address
//   helper. Operand {rdy,tag,val} fields live in ls_operand_slot instances.
//   The destination tag is kept in its own array because its width follows
//   the TAG_W parameter of the top.
package ls_issue_queue_pkg;

   localparam int LS_TAG_W  = 6;
   localparam int LS_ADDR_W = 16;
   localparam int LS_IMM_W  = 16;
   localparam int LS_VAL_W  = 32;

   typedef enum logic {
      LS_LOAD  = 1'b0,
      LS_STORE = 1'b1
   } ls_op_e;

   typedef struct packed {
      ls_op_e              op;
      logic [LS_IMM_W-1:0] imm;
   } ls_entry_ctl_t;

   // 32-bit base + sign-extended offset, carry discarded
   function automatic logic [LS_VAL_W-1:0] ls_eff_addr(
      input logic [LS_VAL_W-1:0] base,
      input logic [LS_IMM_W-1:0] imm
   );
      return base + {{(LS_VAL_W-LS_IMM_W){imm[LS_IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/ls_issue_queue_operand_slot.sv
// ls_operand_slot
//   One operand register {rdy,tag,val} with CDB capture.
//   Ports:
//     clk, rst                 clock / async active-high reset
//     wr_en                    entry is being written by dispatch this cycle
//     wr_rdy, wr_tag, wr_val   operand as offered by dispatch
//     cdb_valid/tag/data       common data bus broadcast
//     rdy, val                 current operand state
//   A dispatch write also checks the same-cycle CDB, so an operand whose
//   producer broadcasts in the dispatch cycle is stored already ready.
module ls_operand_slot
   import ls_issue_queue_pkg::*;
#(
   parameter int TAG_W = LS_TAG_W
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic                wr_rdy,
   input  logic [TAG_W-1:0]    wr_tag,
   input  logic [LS_VAL_W-1:0] wr_val,
   input  logic                cdb_valid,
   input  logic [TAG_W-1:0]    cdb_tag,
   input  logic [LS_VAL_W-1:0] cdb_data,
   output logic                rdy,
   output logic [LS_VAL_W-1:0] val
);

   logic [TAG_W-1:0] tag;
   logic             wr_hit;
   logic             snoop_hit;

   assign wr_hit    = cdb_valid && (cdb_tag == wr_tag);
   assign snoop_hit = cdb_valid && !rdy && (cdb_tag == tag);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy <= 1'b0;
         tag <= '0;
         val <= '0;
      end else if (wr_en) begin
         tag <= wr_tag;
         if (wr_rdy) begin
            rdy <= 1'b1;
            val <= wr_val;
         end else if (wr_hit) begin
            rdy <= 1'b1;
            val <= cdb_data;
         end else begin
            rdy <= 1'b0;
            val <= wr_val;
         end
      end else if (snoop_hit) begin
         rdy <= 1'b1;
         val <= cdb_data;
      end
   end

endmodule

// File: rtl/ls_issue_queue.sv
// ls_issue_queue
//   In-order load/store issue queue feeding the data cache. Ops arrive from
//   dispatch with possibly pending operands, wake up by snooping the CDB,
//   and issue strictly from the head once both operands are ready.
//   Ports:
//     clk, rst, flush             clock, async active-high reset, sync squash
//     disp_*                      dispatch handshake and op payload
//     cdb_valid/tag/data          result broadcast bus
//     dc_en/wen/addr/wdata/tag    registered cache request (one-cycle pulse)
//     count                       occupied entries, 0..DEPTH
module ls_issue_queue
   import ls_issue_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = LS_TAG_W,
   parameter int ADDR_W = LS_ADDR_W
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   disp_valid,
   output logic                   disp_ready,
   input  logic                   disp_is_store,
   input  logic [LS_IMM_W-1:0]    disp_imm,
   input  logic                   disp_base_rdy,
   input  logic [TAG_W-1:0]       disp_base_tag,
   input  logic [LS_VAL_W-1:0]    disp_base_val,
   input  logic                   disp_data_rdy,
   input  logic [TAG_W-1:0]       disp_data_tag,
   input  logic [LS_VAL_W-1:0]    disp_data_val,
   input  logic [TAG_W-1:0]       disp_dest_tag,
   input  logic                   cdb_valid,
   input  logic [TAG_W-1:0]       cdb_tag,
   input  logic [LS_VAL_W-1:0]    cdb_data,
   output logic                   dc_en,
   output logic                   dc_wen,
   output logic [ADDR_W-1:0]      dc_addr,
   output logic [LS_VAL_W-1:0]    dc_wdata,
   output logic [TAG_W-1:0]       dc_tag,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]    head;
   logic [PTR_W-1:0]    tail;
   logic [DEPTH-1:0]    valid;
   ls_entry_ctl_t       ctl      [DEPTH];
   logic [TAG_W-1:0]    dest     [DEPTH];
   logic [DEPTH-1:0]    base_rdy;
   logic [DEPTH-1:0]    data_rdy;
   logic [LS_VAL_W-1:0] base_val [DEPTH];
   logic [LS_VAL_W-1:0] data_val [DEPTH];
   logic                push;
   logic                pop;
   logic                head_ready;
   logic                disp_data_ok;

   // readiness comes from the registered count only, so a pop in the same
   // cycle never opens a slot for that cycle's dispatch
   assign disp_ready   = (count < CNT_W'(DEPTH));
   assign push         = disp_valid && disp_ready && !flush;
   assign head_ready   = valid[head] && base_rdy[head] && data_rdy[head];
   assign pop          = head_ready && !flush;
   // loads have no data operand; store it as ready so it never blocks
   assign disp_data_ok = disp_data_rdy || !disp_is_store;

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic wr_here;
      assign wr_here = push && (tail == PTR_W'(i));

      ls_operand_slot #(.TAG_W(TAG_W)) u_base (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (wr_here),
         .wr_rdy    (disp_base_rdy),
         .wr_tag    (disp_base_tag),
         .wr_val    (disp_base_val),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_tag),
         .cdb_data  (cdb_data),
         .rdy       (base_rdy[i]),
         .val       (base_val[i])
      );

      ls_operand_slot #(.TAG_W(TAG_W)) u_data (
         .clk       (clk),
         .rst       (rst),
         .wr_en     (wr_here),
         .wr_rdy    (disp_data_ok),
         .wr_tag    (disp_data_tag),
         .wr_val    (disp_data_val),
         .cdb_valid (cdb_valid),
         .cdb_tag   (cdb_tag),
         .cdb_data  (cdb_data),
         .rdy       (data_rdy[i]),
         .val       (data_val[i])
      );
   end

   // payload needs no reset: it is only read behind a valid bit
   always_ff @(posedge clk) begin
      if (push) begin
         ctl[tail]  <= '{op: ls_op_e'(disp_is_store), imm: disp_imm};
         dest[tail] <= disp_dest_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         valid <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            valid[tail] <= 1'b1;
            tail        <= tail + PTR_W'(1);
         end
         if (pop) begin
            valid[head] <= 1'b0;
            head        <= head + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // cache request register; addr/wdata/tag hold between pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dc_en    <= 1'b0;
         dc_wen   <= 1'b0;
         dc_addr  <= '0;
         dc_wdata <= '0;
         dc_tag   <= '0;
      end else if (pop) begin
         dc_en    <= 1'b1;
         dc_wen   <= (ctl[head].op == LS_STORE);
         dc_addr  <= ADDR_W'(ls_eff_addr(base_val[head], ctl[head].imm));
         dc_wdata <= (ctl[head].op == LS_STORE) ? data_val[head] : '0;
         dc_tag   <= dest[head];
      end else begin
         dc_en    <= 1'b0;
         dc_wen   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ls_issue_queue.sv
module tb_ls_issue_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush;
   logic        disp_valid;
   logic        disp_ready;
   logic        disp_is_store;
   logic [15:0] disp_imm;
   logic        disp_base_rdy;
   logic [5:0]  disp_base_tag;
   logic [31:0] disp_base_val;
   logic        disp_data_rdy;
   logic [5:0]  disp_data_tag;
   logic [31:0] disp_data_val;
   logic [5:0]  disp_dest_tag;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        dc_en;
   logic        dc_wen;
   logic [15:0] dc_addr;
   logic [31:0] dc_wdata;
   logic [5:0]  dc_tag;
   logic [2:0]  count;

   int errors = 0;
   int checks = 0;

   ls_issue_queue #(.DEPTH(DEPTH), .TAG_W(6), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready),
      .disp_is_store(disp_is_store), .disp_imm(disp_imm),
      .disp_base_rdy(disp_base_rdy), .disp_base_tag(disp_base_tag),
      .disp_base_val(disp_base_val), .disp_data_rdy(disp_data_rdy),
      .disp_data_tag(disp_data_tag), .disp_data_val(disp_data_val),
      .disp_dest_tag(disp_dest_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .dc_en(dc_en), .dc_wen(dc_wen), .dc_addr(dc_addr),
      .dc_wdata(dc_wdata), .dc_tag(dc_tag), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model: a program-order list of ops ----------
   typedef struct {
      bit          st;
      logic [15:0] imm;
      bit          brdy;
      logic [5:0]  btag;
      logic [31:0] bval;
      bit          drdy;
      logic [5:0]  dtag;
      logic [31:0] dval;
      logic [5:0]  dest;
   } op_t;

   op_t         m_q[$];
   bit          m_en, m_wen;
   logic [15:0] m_addr;
   logic [31:0] m_wdata;
   logic [5:0]  m_tag;

   task automatic model_clear_all();
      m_q.delete();
      m_en = 0; m_wen = 0; m_addr = '0; m_wdata = '0; m_tag = '0;
   endtask

   // advance the model across one clock edge using the current inputs
   task automatic model_step();
      op_t         e;
      logic [31:0] sum;
      bit          acc;
      bit          iss;
      acc = disp_valid && (m_q.size() < DEPTH);
      iss = (m_q.size() > 0) && m_q[0].brdy && m_q[0].drdy;
      if (flush) begin
         m_q.delete();
         m_en = 0; m_wen = 0;
         return;
      end
      if (iss) begin
         e = m_q[0];
         sum = e.bval + 32'(signed'(e.imm));
         m_en = 1; m_wen = e.st;
         m_addr = sum[15:0];
         m_wdata = e.st ? e.dval : 32'h0;
         m_tag = e.dest;
      end else begin
         m_en = 0; m_wen = 0;
      end
      if (cdb_valid) begin
         foreach (m_q[i]) begin
            if (!m_q[i].brdy && m_q[i].btag == cdb_tag) begin
               m_q[i].brdy = 1; m_q[i].bval = cdb_data;
            end
            if (!m_q[i].drdy && m_q[i].dtag == cdb_tag) begin
               m_q[i].drdy = 1; m_q[i].dval = cdb_data;
            end
         end
      end
      if (iss) void'(m_q.pop_front());
      if (acc) begin
         e.st = disp_is_store; e.imm = disp_imm;
         e.brdy = disp_base_rdy; e.btag = disp_base_tag; e.bval = disp_base_val;
         e.drdy = disp_data_rdy || !disp_is_store;
         e.dtag = disp_data_tag; e.dval = disp_data_val; e.dest = disp_dest_tag;
         if (!e.brdy && cdb_valid && cdb_tag == e.btag) begin e.brdy = 1; e.bval = cdb_data; end
         if (!e.drdy && cdb_valid && cdb_tag == e.dtag) begin e.drdy = 1; e.dval = cdb_data; end
         m_q.push_back(e);
      end
   endtask

   // ---------------- stimulus helpers --------------------------------------
   task automatic idle_inputs();
      flush = 0; disp_valid = 0; disp_is_store = 0; disp_imm = '0;
      disp_base_rdy = 0; disp_base_tag = '0; disp_base_val = '0;
      disp_data_rdy = 0; disp_data_tag = '0; disp_data_val = '0;
      disp_dest_tag = '0; cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_disp(input bit st, input logic [15:0] imm,
                           input bit brdy, input logic [5:0] btag, input logic [31:0] bval,
                           input bit drdy, input logic [5:0] dtag, input logic [31:0] dval,
                           input logic [5:0] dest);
      disp_valid = 1; disp_is_store = st; disp_imm = imm;
      disp_base_rdy = brdy; disp_base_tag = btag; disp_base_val = bval;
      disp_data_rdy = drdy; disp_data_tag = dtag; disp_data_val = dval;
      disp_dest_tag = dest;
   endtask

   // ---------------- tests -------------------------------------------------
   task automatic test_reset();
      idle_inputs();
      rst = 1;
      #12;
      checks++;
      if (dc_en !== 1'b0 || count !== 3'd0 || dc_addr !== 16'h0) begin
         errors++;
         $display("FAIL reset_hold: en=%b count=%0d addr=%h required 0/0/0", dc_en, count, dc_addr);
      end
      @(negedge clk);
      rst = 0;
      tick();
      checks++;
      if (disp_ready !== 1'b1 || dc_wen !== 1'b0 || dc_tag !== 6'd0 || dc_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_release: ready=%b wen=%b tag=%0d wdata=%h required 1/0/0/0",
                  disp_ready, dc_wen, dc_tag, dc_wdata);
      end
   endtask

   task automatic test_load_ready();
      set_disp(0, 16'h0004, 1, 6'd0, 32'h0000_0100, 0, 6'd0, 32'h0, 6'd5);
      tick();
      idle_inputs();
      checks++;
      if (dc_en !== 1'b0 || count !== 3'd1) begin
         errors++;
         $display("FAIL load_latency: en=%b count=%0d required 0/1", dc_en, count);
      end
      tick();
      checks++;
      if (dc_en !== 1'b1 || dc_wen !== 1'b0 || dc_addr !== 16'h0104 || dc_tag !== 6'd5 ||
          dc_wdata !== 32'h0 || count !== 3'd0) begin
         errors++;
         $display("FAIL load_issue: en=%b wen=%b addr=%h tag=%0d wdata=%h count=%0d required 1/0/0104/5/0/0",
                  dc_en, dc_wen, dc_addr, dc_tag, dc_wdata, count);
      end
      tick();
      checks++;
      if (dc_en !== 1'b0 || dc_addr !== 16'h0104) begin
         errors++;
         $display("FAIL load_pulse_hold: en=%b addr=%h required 0/0104", dc_en, dc_addr);
      end
   endtask

   task automatic test_store_wrap();
      set_disp(1, 16'hFFFC, 1, 6'd0, 32'h0000_0002, 1, 6'd0, 32'hDEAD_BEEF, 6'd7);
      tick();
      idle_inputs();
      tick();
      checks++;
      if (dc_en !== 1'b1 || dc_wen !== 1'b1 || dc_addr !== 16'hFFFE ||
          dc_wdata !== 32'hDEAD_BEEF || dc_tag !== 6'd7) begin
         errors++;
         $display("FAIL store_wrap: en=%b wen=%b addr=%h wdata=%h tag=%0d required 1/1/FFFE/DEADBEEF/7",
                  dc_en, dc_wen, dc_addr, dc_wdata, dc_tag);
      end
   endtask

   task automatic test_cdb_wakeup();
      set_disp(1, 16'h0010, 0, 6'd9, 32'h0, 1, 6'd0, 32'h0000_1234, 6'd11);
      tick();
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (dc_en !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL wakeup_wait%0d: en=%b count=%0d required 0/1", k, dc_en, count);
         end
      end
      cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'h0000_0200;
      tick();
      idle_inputs();
      checks++;
      if (dc_en !== 1'b0) begin
         errors++;
         $display("FAIL wakeup_capture_edge: en=%b required 0", dc_en);
      end
      tick();
      checks++;
      if (dc_en !== 1'b1 || dc_wen !== 1'b1 || dc_addr !== 16'h0210 ||
          dc_wdata !== 32'h0000_1234 || dc_tag !== 6'd11) begin
         errors++;
         $display("FAIL wakeup_issue: en=%b wen=%b addr=%h wdata=%h tag=%0d required 1/1/0210/00001234/11",
                  dc_en, dc_wen, dc_addr, dc_wdata, dc_tag);
      end
      set_disp(0, 16'h0004, 0, 6'd9, 32'h0, 0, 6'd0, 32'h0, 6'd12);
      cdb_valid = 1; cdb_tag = 6'd9; cdb_data = 32'h0000_0300;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (dc_en !== 1'b1 || dc_wen !== 1'b0 || dc_addr !== 16'h0304 || dc_tag !== 6'd12) begin
         errors++;
         $display("FAIL disp_cdb_same_cycle: en=%b wen=%b addr=%h tag=%0d required 1/0/0304/12",
                  dc_en, dc_wen, dc_addr, dc_tag);
      end
   endtask

   task automatic test_full_block();
      logic [15:0] exp_addr [4];
      exp_addr[0] = 16'h0040; exp_addr[1] = 16'h1000;
      exp_addr[2] = 16'h2000; exp_addr[3] = 16'h3000;
      set_disp(0, 16'h0000, 0, 6'd3, 32'h0, 0, 6'd0, 32'h0, 6'd20);
      tick();
      for (int k = 1; k < 4; k++) begin
         set_disp(0, 16'h0000, 1, 6'd0, 32'(k) << 12, 0, 6'd0, 32'h0, 6'(20 + k));
         tick();
      end
      checks++;
      if (count !== 3'd4 || disp_ready !== 1'b0 || dc_en !== 1'b0) begin
         errors++;
         $display("FAIL full_state: count=%0d ready=%b en=%b required 4/0/0", count, disp_ready, dc_en);
      end
      // offered while full: must be refused
      set_disp(0, 16'h0000, 1, 6'd0, 32'h0000_7000, 0, 6'd0, 32'h0, 6'd30);
      tick();
      idle_inputs();
      checks++;
      if (count !== 3'd4 || dc_en !== 1'b0) begin
         errors++;
         $display("FAIL full_refuse: count=%0d en=%b required 4/0", count, dc_en);
      end
      cdb_valid = 1; cdb_tag = 6'd3; cdb_data = 32'h0000_0040;
      tick();
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (dc_en !== 1'b1 || dc_tag !== 6'(20 + k) || dc_addr !== exp_addr[k] ||
             count !== 3'(3 - k) || disp_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain%0d: en=%b tag=%0d addr=%h count=%0d ready=%b required 1/%0d/%h/%0d/1",
                     k, dc_en, dc_tag, dc_addr, count, disp_ready, 20 + k, exp_addr[k], 3 - k);
         end
      end
      tick();
      checks++;
      if (dc_en !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL drain_done: en=%b count=%0d required 0/0", dc_en, count);
      end
   endtask

   task automatic test_flush();
      set_disp(0, 16'h0000, 0, 6'd40, 32'h0, 0, 6'd0, 32'h0, 6'd44);
      tick();
      set_disp(0, 16'h0000, 0, 6'd41, 32'h0, 0, 6'd0, 32'h0, 6'd45);
      tick();
      set_disp(0, 16'h0000, 1, 6'd0, 32'h0000_0500, 0, 6'd0, 32'h0, 6'd50);
      flush = 1;
      tick();
      idle_inputs();
      checks++;
      if (count !== 3'd0 || dc_en !== 1'b0 || disp_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_clear: count=%0d en=%b ready=%b required 0/0/1", count, dc_en, disp_ready);
      end
      for (int k = 0; k < 4; k++) begin
         cdb_valid = (k < 2); cdb_tag = 6'(40 + k); cdb_data = 32'h0000_0800;
         tick();
         checks++;
         if (dc_en !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL flush_stale%0d: en=%b count=%0d required 0/0", k, dc_en, count);
         end
      end
      idle_inputs();
      // flush in the cycle a ready head would issue
      set_disp(0, 16'h0000, 1, 6'd0, 32'h0000_0600, 0, 6'd0, 32'h0, 6'd51);
      tick();
      idle_inputs();
      flush = 1;
      tick();
      flush = 0;
      checks++;
      if (dc_en !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL flush_vs_issue: en=%b count=%0d required 0/0", dc_en, count);
      end
   endtask

   task automatic test_async_reset();
      set_disp(0, 16'h0001, 1, 6'd0, 32'h0000_0A00, 0, 6'd0, 32'h0, 6'd33);
      tick();
      set_disp(1, 16'h0002, 1, 6'd0, 32'h0000_0B00, 1, 6'd0, 32'h1111_2222, 6'd34);
      tick();
      idle_inputs();
      checks++;
      if (dc_en !== 1'b1 || count !== 3'd1 || dc_addr !== 16'h0A01) begin
         errors++;
         $display("FAIL pre_reset: en=%b count=%0d addr=%h required 1/1/0A01", dc_en, count, dc_addr);
      end
      #2;
      rst = 1;
      #1;
      checks++;
      if (dc_en !== 1'b0 || dc_wen !== 1'b0 || dc_addr !== 16'h0 || dc_wdata !== 32'h0 ||
          dc_tag !== 6'd0 || count !== 3'd0 || disp_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: en=%b wen=%b addr=%h wdata=%h tag=%0d count=%0d ready=%b required all 0, ready 1",
                  dc_en, dc_wen, dc_addr, dc_wdata, dc_tag, count, disp_ready);
      end
      @(negedge clk);
      rst = 0;
      tick();
      tick();
      checks++;
      if (dc_en !== 1'b0 || count !== 3'd0) begin
         errors++;
         $display("FAIL post_reset: en=%b count=%0d required 0/0", dc_en, count);
      end
   endtask

   task automatic test_random();
      idle_inputs();
      rst = 1;
      #3;
      model_clear_all();
      @(negedge clk);
      rst = 0;
      tick();
      for (int n = 0; n < 600; n++) begin
         idle_inputs();
         disp_valid    = ($urandom_range(0, 9) < 6);
         disp_is_store = $urandom_range(0, 1);
         disp_imm      = 16'($urandom);
         disp_base_rdy = $urandom_range(0, 1);
         disp_base_tag = 6'($urandom_range(0, 7));
         disp_base_val = $urandom;
         disp_data_rdy = $urandom_range(0, 1);
         disp_data_tag = 6'($urandom_range(0, 7));
         disp_data_val = $urandom;
         disp_dest_tag = 6'($urandom);
         cdb_valid     = ($urandom_range(0, 9) < 4);
         cdb_tag       = 6'($urandom_range(0, 7));
         cdb_data      = $urandom;
         flush         = ($urandom_range(0, 31) == 0);
         checks++;
         if (disp_ready !== (m_q.size() < DEPTH)) begin
            errors++;
            $display("FAIL rnd_ready@%0d: got %b required %b", n, disp_ready, m_q.size() < DEPTH);
         end
         model_step();
         tick();
         checks++;
         if (dc_en !== m_en || dc_wen !== m_wen || dc_addr !== m_addr ||
             dc_wdata !== m_wdata || dc_tag !== m_tag) begin
            errors++;
            $display("FAIL rnd_dc@%0d: en=%b wen=%b addr=%h wdata=%h tag=%0d required %b/%b/%h/%h/%0d",
                     n, dc_en, dc_wen, dc_addr, dc_wdata, dc_tag, m_en, m_wen, m_addr, m_wdata, m_tag);
         end
         checks++;
         if (count !== 3'(m_q.size())) begin
            errors++;
            $display("FAIL rnd_count@%0d: got %0d required %0d", n, count, m_q.size());
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_load_ready();
      test_store_wrap();
      test_cdb_wakeup();
      test_full_block();
      test_flush();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
